fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Implements the FETCH stage controlled by the core's stage-sequencing FSM. When its stage-active bit is asserted, it reads one 32-bit instruction at the current PC over the core's byte-wide memory bus, one byte per request/acknowledge handshake, little-endian. It presents the assembled instruction to DECODE and raises its stage-done bit. PC alignment is checked before any bus traffic.

Parameters:
ADDR_WIDTH, 32, width of pc and mem_addr
CHECK_ALIGN, 1, 1 = flag pc[1:0]!=0 as misaligned without touching the bus; 0 = ignore pc[1:0] and force them to 0

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on the clk rising edge; 0 = reset
active  input  1  FETCH bit of the FSM's stage_active vector
pc  input  ADDR_WIDTH  program counter; sampled only on the start edge
done  output  1  FETCH bit of the FSM's stage_done vector
instr  output  32  assembled instruction; valid while done=1
misaligned  output  1  fetch faulted on alignment; valid while done=1
mem_req  output  1  byte read request
mem_addr  output  ADDR_WIDTH  byte address; stable while mem_req=1
mem_ack  input  1  slave completes the byte this cycle; ignored when mem_req=0
mem_rdata  input  8  read data; valid in a cycle with mem_req & mem_ack

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; done=0, mem_req=0, misaligned=0, instr=0, mem_addr=0, byte index=0. Reset overrides everything, including a mid-transfer fetch; an ack arriving on the reset edge is discarded.
- States: IDLE, BUS, DONE. All outputs are registered.
- IDLE: on an edge with active=1:
  - pc aligned or CHECK_ALIGN=0: latch base={pc[AW-1:2],2'b00}, clear instr, idx=0, mem_req=1, mem_addr=base, go to BUS.
  - otherwise: instr=0, misaligned=1, done=1, go to DONE. mem_req stays 0.
- BUS: mem_req=1, mem_addr=base+idx (idx 0..3).
  - Edge with mem_ack=1: instr[8*idx+:8]=mem_rdata, then:
    - idx<3: idx++ and mem_addr advances on the same edge.
    - idx==3: mem_req=0, done=1, misaligned=0, go to DONE.
  - mem_ack=0: hold everything. There is no timeout; wait states are unbounded.
- DONE: hold done, instr and misaligned while active=1. On an edge with active=0: done=0, misaligned=0, go to IDLE. instr retains its value until the next fetch starts.
- Active dropped while in BUS (FSM protocol violation): next edge mem_req=0, state=IDLE, partial instr discarded, done stays 0. An ack coincident with that edge is ignored. Slaves must tolerate request withdrawal.
- The FSM's mandatory stall cycle guarantees active is low for at least one edge between fetches. done is therefore always 0 when active next rises.
- pc changes after the start edge have no effect.
- Minimum latency (zero-wait slave, ack held high): start edge E0, bytes captured at E1..E4, done=1 after E4. That is 5 cycles from the first edge sampling active=1. Each wait cycle adds 1.
- Misaligned latency: done=1 after E0 (1 cycle).
- mem_addr arithmetic is modulo 2^ADDR_WIDTH. Because base is word-aligned, no carry out of bit 1 occurs.

Test Plan:
- Zero-wait fetch: pc=0x100, slave returns 0x93,0x00,0x50,0x00 with ack held high → mem_addr 0x100,0x101,0x102,0x103 on consecutive cycles; done=1 after E4; instr=0x00500093; misaligned=0.
- Wait states: same fetch, ack asserted only every 3rd cycle of mem_req → mem_addr holds 3 cycles per byte; done after 12 BUS cycles; instr=0x00500093.
- Misaligned: pc=0x102, CHECK_ALIGN=1 → mem_req never asserts; done=1 and misaligned=1 one cycle after start; instr=0. Repeat with CHECK_ALIGN=0 → bytes read from 0x100..0x103.
- Reset mid-fetch: assert reset=0 after 2 bytes captured → next edge mem_req=0, done=0, instr=0. Fetch at pc=0x200 after release → clean 4-byte read from 0x200.
- Handoff: hold active=1 for 3 cycles after done, then drop → done, instr and misaligned stable while active=1; done=0 one edge after active=0; instr retained.
- Back-to-back fetches with active low for exactly one edge between them, pc 0x0 then 0x4 → two correct instructions; done=0 on the edge active rises the second time.

Source files
------------

// File: rtl/fetch_unit.sv
// FETCH stage: reads one little-endian 32-bit instruction at pc over a byte-wide
// request/acknowledge bus, with an optional alignment check before any bus traffic.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  done,
    output logic [31:0]           instr,
    output logic                  misaligned,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           instr_q, instr_d;
    logic                  done_q, done_d;
    logic                  misaligned_q, misaligned_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]            idx_next;
    logic [ADDR_WIDTH-1:0] pc_base;

    assign idx_next = idx_q + 2'd1;
    assign pc_base  = {pc[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        idx_d        = idx_q;
        instr_d      = instr_q;
        done_d       = done_q;
        misaligned_d = misaligned_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;

        case (state_q)
            IDLE: begin
                if (active) begin
                    if (CHECK_ALIGN && (pc[1:0] != 2'b00)) begin
                        instr_d      = 32'd0;
                        misaligned_d = 1'b1;
                        done_d       = 1'b1;
                        state_d      = DONE;
                    end else begin
                        base_d     = pc_base;
                        instr_d    = 32'd0;
                        idx_d      = 2'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_base;
                        state_d    = BUS;
                    end
                end
            end
            BUS: begin
                // Withdrawing active mid-transfer abandons the word; any coincident ack is dropped.
                if (!active) begin
                    mem_req_d = 1'b0;
                    instr_d   = 32'd0;
                    idx_d     = 2'd0;
                    state_d   = IDLE;
                end else if (mem_ack) begin
                    instr_d[8*idx_q +: 8] = mem_rdata;
                    if (idx_q == 2'd3) begin
                        mem_req_d    = 1'b0;
                        done_d       = 1'b1;
                        misaligned_d = 1'b0;
                        state_d      = DONE;
                    end else begin
                        idx_d      = idx_next;
                        mem_addr_d = base_q + ADDR_WIDTH'(idx_next);
                    end
                end
            end
            DONE: begin
                if (!active) begin
                    done_d       = 1'b0;
                    misaligned_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            idx_q        <= 2'd0;
            instr_q      <= 32'd0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            instr_q      <= instr_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign done       = done_q;
    assign instr      = instr_q;
    assign misaligned = misaligned_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (alignment check on / off) share stimulus,
// each with its own byte slave, checked every cycle against a behavioural model.
module tb_fetch_unit;

    localparam int AW = 32;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        active = 1'b0;
    logic [31:0] pc     = 32'd0;

    logic        done_o  [2];
    logic        mis_o   [2];
    logic        req_o   [2];
    logic [31:0] instr_o [2];
    logic [31:0] addr_o  [2];
    logic        ack_i   [2];
    logic [7:0]  rdata_i [2];

    fetch_unit #(.ADDR_WIDTH(AW), .CHECK_ALIGN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .active(active), .pc(pc),
        .done(done_o[0]), .instr(instr_o[0]), .misaligned(mis_o[0]),
        .mem_req(req_o[0]), .mem_addr(addr_o[0]),
        .mem_ack(ack_i[0]), .mem_rdata(rdata_i[0])
    );

    fetch_unit #(.ADDR_WIDTH(AW), .CHECK_ALIGN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .active(active), .pc(pc),
        .done(done_o[1]), .instr(instr_o[1]), .misaligned(mis_o[1]),
        .mem_req(req_o[1]), .mem_addr(addr_o[1]),
        .mem_ack(ack_i[1]), .mem_rdata(rdata_i[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    // Slave behaviour: ack held high, or ack on every (wait_n+1)-th cycle of a request
    bit ack_always = 1'b1;
    int wait_n = 0;
    int wait_cnt [2] = '{0, 0};

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: mem_byte = 8'h93;
            32'h101: mem_byte = 8'h00;
            32'h102: mem_byte = 8'h50;
            32'h103: mem_byte = 8'h00;
            32'h200: mem_byte = 8'h13;
            32'h201: mem_byte = 8'h01;
            32'h202: mem_byte = 8'h10;
            32'h203: mem_byte = 8'h00;
            32'h000: mem_byte = 8'hb7;
            32'h001: mem_byte = 8'h10;
            32'h002: mem_byte = 8'h00;
            32'h003: mem_byte = 8'h00;
            32'h004: mem_byte = 8'h23;
            32'h005: mem_byte = 8'ha0;
            32'h006: mem_byte = 8'h20;
            32'h007: mem_byte = 8'h00;
            default: mem_byte = a[7:0] ^ 8'h5a;
        endcase
    endfunction

    // First n bytes of the little-endian word at base, upper bytes zero
    function automatic logic [31:0] assemble(input logic [31:0] base, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mem_byte(base + 32'(k));
        return r;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ack_always) begin
                ack_i[i] = 1'b1;
            end else if (req_o[i]) begin
                if (wait_cnt[i] == wait_n) begin
                    ack_i[i] = 1'b1;
                    wait_cnt[i] = 0;
                end else begin
                    ack_i[i] = 1'b0;
                    wait_cnt[i] = wait_cnt[i] + 1;
                end
            end else begin
                ack_i[i] = 1'b0;
                wait_cnt[i] = 0;
            end
            rdata_i[i] = req_o[i] ? mem_byte(addr_o[i]) : 8'hee;
        end
    end

    // Behavioural model: phase 0 waiting, 1 reading bytes, 2 presenting result
    int          m_phase [2];
    int          m_cnt   [2];
    logic [31:0] m_base  [2];
    logic        exp_done  [2];
    logic        exp_mis   [2];
    logic        exp_req   [2];
    logic [31:0] exp_instr [2];
    logic [31:0] exp_addr  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_phase[i] = 0; m_cnt[i] = 0; m_base[i] = 32'd0;
                exp_done[i] = 1'b0; exp_mis[i] = 1'b0; exp_req[i] = 1'b0;
                exp_instr[i] = 32'd0; exp_addr[i] = 32'd0;
            end else begin
                case (m_phase[i])
                    0: if (active) begin
                        if (i == 0 && pc[1:0] != 2'b00) begin
                            exp_instr[i] = 32'd0;
                            exp_mis[i] = 1'b1;
                            exp_done[i] = 1'b1;
                            m_phase[i] = 2;
                        end else begin
                            m_base[i] = pc & ~32'h3;
                            m_cnt[i] = 0;
                            exp_instr[i] = 32'd0;
                            exp_req[i] = 1'b1;
                            exp_addr[i] = m_base[i];
                            m_phase[i] = 1;
                        end
                    end
                    1: if (!active) begin
                        exp_req[i] = 1'b0;
                        exp_instr[i] = 32'd0;
                        m_cnt[i] = 0;
                        m_phase[i] = 0;
                    end else if (ack_i[i]) begin
                        m_cnt[i] = m_cnt[i] + 1;
                        exp_instr[i] = assemble(m_base[i], m_cnt[i]);
                        if (m_cnt[i] == 4) begin
                            exp_req[i] = 1'b0;
                            exp_done[i] = 1'b1;
                            exp_mis[i] = 1'b0;
                            m_phase[i] = 2;
                        end else begin
                            exp_addr[i] = m_base[i] + 32'(m_cnt[i]);
                        end
                    end
                    default: if (!active) begin
                        exp_done[i] = 1'b0;
                        exp_mis[i] = 1'b0;
                        m_phase[i] = 0;
                    end
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(exp_done[i]));
                checkOutput($sformatf("misaligned[%0d]", i), 32'(mis_o[i]), 32'(exp_mis[i]));
                checkOutput($sformatf("mem_req[%0d]", i), 32'(req_o[i]), 32'(exp_req[i]));
                checkOutput($sformatf("instr[%0d]", i), instr_o[i], exp_instr[i]);
                if (exp_req[i]) checkOutput($sformatf("mem_addr[%0d]", i), addr_o[i], exp_addr[i]);
            end
        end
    end

    // Start a fetch, wait for both instances to finish, hold active, then drop it
    task automatic applyStimulus(input logic [31:0] p, input int hold, output int lat_a, output int lat_b);
        @(negedge clk);
        pc = p;
        active = 1'b1;
        lat_a = 0;
        lat_b = 0;
        for (int c = 1; c <= 100 && (lat_a == 0 || lat_b == 0); c++) begin
            @(negedge clk);
            if (c == 1) pc = 32'h0bad_f00d;
            if (lat_a == 0 && done_o[0]) lat_a = c;
            if (lat_b == 0 && done_o[1]) lat_b = c;
        end
        if (lat_a == 0 || lat_b == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL fetch_timeout pc=%h: done_a=%b done_b=%b, expected both 1", p, done_o[0], done_o[1]);
        end
        repeat (hold) @(negedge clk);
        active = 1'b0;
    endtask

    int la, lb;

    initial begin
        for (int i = 0; i < 2; i++) begin ack_i[i] = 1'b0; rdata_i[i] = 8'h00; end
        reset = 1'b0;
        active = 1'b0;
        repeat (2) @(negedge clk);
        compare_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_done", 32'(done_o[i]), 32'd0);
            checkOutput("reset_req", 32'(req_o[i]), 32'd0);
            checkOutput("reset_instr", instr_o[i], 32'd0);
            checkOutput("reset_addr", addr_o[i], 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] zero-wait fetch at 0x100");
        ack_always = 1'b1;
        applyStimulus(32'h100, 0, la, lb);
        checkOutput("lat_zero_wait_a", 32'(la), 32'd5);
        checkOutput("lat_zero_wait_b", 32'(lb), 32'd5);
        checkOutput("instr_zero_wait", instr_o[0], 32'h00500093);
        checkOutput("model_pin_zero_wait", exp_instr[0], 32'h00500093);

        $display("[TB] wait-state fetch at 0x100");
        ack_always = 1'b0;
        wait_n = 2;
        applyStimulus(32'h100, 0, la, lb);
        checkOutput("lat_wait_a", 32'(la), 32'd13);
        checkOutput("instr_wait", instr_o[0], 32'h00500093);

        $display("[TB] misaligned fetch at 0x102");
        ack_always = 1'b1;
        applyStimulus(32'h102, 0, la, lb);
        checkOutput("lat_misaligned_a", 32'(la), 32'd1);
        checkOutput("lat_noalign_b", 32'(lb), 32'd5);
        checkOutput("misaligned_a", 32'(mis_o[0]), 32'd1);
        checkOutput("instr_misaligned_a", instr_o[0], 32'd0);
        checkOutput("misaligned_b", 32'(mis_o[1]), 32'd0);
        checkOutput("instr_noalign_b", instr_o[1], 32'h00500093);

        $display("[TB] back-to-back fetches at 0x0 and 0x4");
        applyStimulus(32'h0, 0, la, lb);
        checkOutput("instr_b2b_first", instr_o[0], 32'h000010b7);
        applyStimulus(32'h4, 0, la, lb);
        checkOutput("lat_b2b_second", 32'(la), 32'd5);
        checkOutput("instr_b2b_second", instr_o[1], 32'h0020a023);

        $display("[TB] handoff with active held after done");
        applyStimulus(32'h0, 3, la, lb);
        @(negedge clk);
        checkOutput("handoff_done_drop", 32'(done_o[0]), 32'd0);
        checkOutput("handoff_instr_kept", instr_o[0], 32'h000010b7);

        $display("[TB] reset mid-fetch");
        @(negedge clk);
        pc = 32'h100;
        active = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("partial_instr", instr_o[0], 32'h00000093);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_req", 32'(req_o[0]), 32'd0);
        checkOutput("midreset_done", 32'(done_o[0]), 32'd0);
        checkOutput("midreset_instr", instr_o[0], 32'd0);
        active = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(32'h200, 0, la, lb);
        checkOutput("lat_after_reset", 32'(la), 32'd5);
        checkOutput("instr_after_reset", instr_o[0], 32'h00100113);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
